// File: rtl/regfile_pkg.sv
// Shared constants for the register-file op sequencer: widths, opcodes and
// FSM state encoding.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SLL   = 3'd5;
  localparam logic [2:0] OP_SRL   = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_EX   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU for the op sequencer: result, zero flag and carry
// (carry-out for ADD, not-borrow for SUB, 0 otherwise).
module regfile_alu
  import regfile_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a >= b);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SLL:   result = a << b[4:0];
      OP_SRL:   result = a >> b[4:0];
      OP_PASSA: result = a;
      default:  result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Register-file initiator: accepts one ALU command at a time, reads both
// sources, computes in the ALU and writes the result back (IDLE->RD->EX->WR).
module regfile_op_sequencer
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  // Command handshake: a command transfers on a rising edge where
  // cmd_valid && cmd_ready; while cmd_ready=0 the source holds the command stable.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_srcA,
  input  logic [ADDR_W-1:0] cmd_srcB,
  input  logic              cmd_nowb,
  output logic [ADDR_W-1:0] rf_rdAddrA,
  output logic [ADDR_W-1:0] rf_rdAddrB,
  input  logic [DATA_W-1:0] rf_rdDataA,
  input  logic [DATA_W-1:0] rf_rdDataB,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0] rf_wrData,
  output logic              rf_write,
  output logic              done,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_carry,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] srca_q, srca_d;
  logic [ADDR_W-1:0] srcb_q, srcb_d;
  logic              nowb_q, nowb_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;

  regfile_alu u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    srca_d    = srca_q;
    srcb_d    = srcb_q;
    nowb_d    = nowb_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          srca_d  = cmd_srcA;
          srcb_d  = cmd_srcB;
          nowb_d  = cmd_nowb;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        opa_d   = rf_rdDataA;
        opb_d   = rf_rdDataB;
        state_d = ST_EX;
      end
      // Result and write address are registered here so WR drives them from flops.
      ST_EX: begin
        res_d     = alu_result;
        zero_d    = alu_zero;
        carry_d   = alu_carry;
        wr_addr_d = dst_q;
        state_d   = ST_WR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      nowb_q    <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      srca_q    <= srca_d;
      srcb_q    <= srcb_d;
      nowb_q    <= nowb_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_WR);
  assign rf_write   = (state_q == ST_WR) && !nowb_q;
  assign rf_rdAddrA = (state_q == ST_RD) ? srca_q : '0;
  assign rf_rdAddrB = (state_q == ST_RD) ? srcb_q : '0;
  assign rf_wrAddr  = wr_addr_q;
  assign rf_wrData  = res_q;
  assign res_data   = res_q;
  assign res_zero   = zero_q;
  assign res_carry  = carry_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 32x32 register
// file attached to its read/write ports.
module tb_regfile_op_sequencer;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst, cmd_srcA, cmd_srcB;
  logic              cmd_nowb;
  logic [ADDR_W-1:0] rf_rdAddrA, rf_rdAddrB, rf_wrAddr;
  logic [DATA_W-1:0] rf_rdDataA, rf_rdDataB, rf_wrData;
  logic              rf_write, done, res_zero, res_carry, busy;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] rf_mem [32];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  int                lat;
  logic              wr_seen, obs_done, obs_zero, obs_carry;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_data, obs_res;

  regfile_op_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_srcA   (cmd_srcA),
    .cmd_srcB   (cmd_srcB),
    .cmd_nowb   (cmd_nowb),
    .rf_rdAddrA (rf_rdAddrA),
    .rf_rdAddrB (rf_rdAddrB),
    .rf_rdDataA (rf_rdDataA),
    .rf_rdDataB (rf_rdDataB),
    .rf_wrAddr  (rf_wrAddr),
    .rf_wrData  (rf_wrData),
    .rf_write   (rf_write),
    .done       (done),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_carry  (res_carry),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / register file model ----------------
  always #5 clk = ~clk;

  assign rf_rdDataA = rf_mem[rf_rdAddrA];
  assign rf_rdDataB = rf_mem[rf_rdAddrB];

  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_wrAddr] <= rf_wrData;
    else if (pre_we) rf_mem[pre_addr] <= pre_data;
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] dst,
                          input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] sb,
                          input logic nowb);
    int guard = 0;
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_srcA = sa; cmd_srcB = sb; cmd_nowb = nowb;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_cmd_ready: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    lat = 0; wr_seen = 1'b0; obs_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (rf_write) begin
        wr_seen = 1'b1; obs_addr = rf_wrAddr; obs_data = rf_wrData;
      end
      if (done) begin
        obs_done = 1'b1; obs_res = res_data; obs_zero = res_zero; obs_carry = res_carry;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({rf_write, done, res_zero, res_carry, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: {wr,done,zero,carry,busy}=%b required 00000",
               {rf_write, done, res_zero, res_carry, busy});
    end
    checks++;
    if ({res_data, rf_wrData, rf_wrAddr, rf_rdAddrA, rf_rdAddrB} !== '0) begin
      errors++;
      $display("FAIL reset_data: res=%h wrd=%h wra=%h ra=%h rb=%h required all 0",
               res_data, rf_wrData, rf_wrAddr, rf_rdAddrA, rf_rdAddrB);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_add_carry();
    send_cmd(OP_ADD, 5'd3, 5'd1, 5'd2, 1'b0);
    wait_done();
    checks++;
    if (obs_done !== 1'b1 || lat != 3) begin
      errors++;
      $display("FAIL add_latency: done=%b latency=%0d required 1 3", obs_done, lat);
    end
    checks++;
    if (wr_seen !== 1'b1 || obs_addr !== 5'd3 || obs_data !== 32'h0000_0001) begin
      errors++;
      $display("FAIL add_write: seen=%b addr=%0d data=%h required 1 3 00000001",
               wr_seen, obs_addr, obs_data);
    end
    checks++;
    if (obs_res !== 32'h0000_0001 || obs_carry !== 1'b1 || obs_zero !== 1'b0) begin
      errors++;
      $display("FAIL add_result: res=%h carry=%b zero=%b required 00000001 1 0",
               obs_res, obs_carry, obs_zero);
    end
    @(negedge clk);
    checks++;
    if (rf_mem[3] !== 32'h0000_0001 || res_data !== 32'h0000_0001 || done !== 1'b0) begin
      errors++;
      $display("FAIL add_readback: r3=%h res=%h done=%b required 00000001 00000001 0",
               rf_mem[3], res_data, done);
    end
  endtask

  task automatic test_sub_zero();
    send_cmd(OP_SUB, 5'd5, 5'd5, 5'd5, 1'b0);
    wait_done();
    checks++;
    if (obs_res !== 32'h0 || obs_zero !== 1'b1 || obs_carry !== 1'b1 || wr_seen !== 1'b1) begin
      errors++;
      $display("FAIL sub_result: res=%h zero=%b carry=%b wr=%b required 00000000 1 1 1",
               obs_res, obs_zero, obs_carry, wr_seen);
    end
    @(negedge clk);
    checks++;
    if (rf_mem[5] !== 32'h0) begin
      errors++;
      $display("FAIL sub_inplace: r5=%h required 00000000", rf_mem[5]);
    end
  endtask

  task automatic test_shifts();
    send_cmd(OP_SLL, 5'd8, 5'd6, 5'd7, 1'b0);
    wait_done();
    checks++;
    if (obs_res !== 32'h1234_5670 || obs_carry !== 1'b0 || obs_addr !== 5'd8) begin
      errors++;
      $display("FAIL sll: res=%h carry=%b addr=%0d required 12345670 0 8",
               obs_res, obs_carry, obs_addr);
    end
    send_cmd(OP_SRL, 5'd9, 5'd6, 5'd7, 1'b0);
    wait_done();
    checks++;
    if (obs_res !== 32'h0012_3456 || obs_addr !== 5'd9) begin
      errors++;
      $display("FAIL srl: res=%h addr=%0d required 00123456 9", obs_res, obs_addr);
    end
    @(negedge clk);
    checks++;
    if (rf_mem[8] !== 32'h1234_5670 || rf_mem[9] !== 32'h0012_3456) begin
      errors++;
      $display("FAIL shift_readback: r8=%h r9=%h required 12345670 00123456",
               rf_mem[8], rf_mem[9]);
    end
  endtask

  task automatic test_nowb();
    send_cmd(OP_PASSA, 5'd11, 5'd10, 5'd0, 1'b1);
    wait_done();
    checks++;
    if (obs_done !== 1'b1 || obs_res !== 32'h5555_5555 || wr_seen !== 1'b0) begin
      errors++;
      $display("FAIL nowb: done=%b res=%h wr_seen=%b required 1 55555555 0",
               obs_done, obs_res, wr_seen);
    end
    @(negedge clk);
    checks++;
    if (rf_mem[11] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL nowb_dst: r11=%h required cafef00d", rf_mem[11]);
    end
  endtask

  task automatic test_reset_mid_ex();
    int wr_cnt = 0;
    send_cmd(OP_ADD, 5'd4, 5'd6, 5'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_EX) begin
      errors++;
      $display("FAIL mid_state: state=%0d required %0d", dbg_state, ST_EX);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({rf_write, done, busy, res_zero, res_carry} !== 5'b0 || res_data !== '0 ||
        rf_wrData !== '0 || rf_wrAddr !== '0 || rf_rdAddrA !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: wr=%b done=%b busy=%b res=%h wrd=%h wra=%0d required all 0",
               rf_write, done, busy, res_data, rf_wrData, rf_wrAddr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rf_write) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 0 || rf_mem[4] !== 32'h1111_1111 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_discard: writes=%0d r4=%h ready=%b required 0 11111111 1",
               wr_cnt, rf_mem[4], cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int first_ready = 0;
    int idle_cnt = 0;
    int wr_cnt = 0;
    logic [DATA_W-1:0] exp_w;
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0001);
    @(negedge clk);
    cmd_op = OP_ADD; cmd_dst = 5'd12; cmd_srcA = 5'd1; cmd_srcB = 5'd2; cmd_nowb = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = OP_AND; cmd_dst = 5'd13; cmd_srcA = 5'd12; cmd_srcB = 5'd12;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (cmd_ready && first_ready == 0) first_ready = i;
      if (rf_write) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_write: data=%h with no write expected", rf_wrData);
        end else begin
          exp_w = exp_q.pop_front();
          if (rf_wrData !== exp_w) begin
            errors++;
            $display("FAIL b2b_wrdata: data=%h required %h", rf_wrData, exp_w);
          end
        end
      end
      if (i == 4) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
    end
    checks++;
    if (first_ready != 4 || idle_cnt != 1 || wr_cnt != 2) begin
      errors++;
      $display("FAIL b2b_timing: ready_cycle=%0d idle_cycles=%0d writes=%0d required 4 1 2",
               first_ready, idle_cnt, wr_cnt);
    end
    @(negedge clk);
    checks++;
    if (rf_mem[12] !== 32'h0000_0001 || rf_mem[13] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_readback: r12=%h r13=%h required 00000001 00000001",
               rf_mem[12], rf_mem[13]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srcA = '0; cmd_srcB = '0;
    cmd_nowb = 1'b0;
    test_reset();
    preload(5'd1,  32'hFFFF_FFFF);
    preload(5'd2,  32'h0000_0002);
    preload(5'd3,  32'hDEAD_BEEF);
    preload(5'd4,  32'h1111_1111);
    preload(5'd5,  32'hABCD_EFAB);
    preload(5'd6,  32'h0123_4567);
    preload(5'd7,  32'h0000_0004);
    preload(5'd10, 32'h5555_5555);
    preload(5'd11, 32'hCAFE_F00D);
    preload(5'd12, 32'hF0F0_F0F0);
    preload(5'd13, 32'h0000_0000);
    test_add_carry();
    test_sub_zero();
    test_shifts();
    test_nowb();
    test_reset_mid_ex();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Initiator/master for the team's 32-entry x 32-bit register file (one write port, two combinational read ports A/B).
- Accepts register-to-register ALU commands over a valid/ready interface, reads both source registers, computes the result and writes it back to the destination register.
- Sits between an upstream command source (test controller or microsequencer) and the register file. One command is in flight at a time.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 entries).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; released synchronously by the integrator).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command this cycle.
- cmd_op  input  3  opcode (see Behaviour).
- cmd_dst  input  ADDR_W  destination register.
- cmd_srcA  input  ADDR_W  source A register.
- cmd_srcB  input  ADDR_W  source B register.
- cmd_nowb  input  1  1 = compute only, suppress write-back.
- rf_rdAddrA  output  ADDR_W  register file read address A.
- rf_rdAddrB  output  ADDR_W  register file read address B.
- rf_rdDataA  input  DATA_W  read data A, combinational from rf_rdAddrA.
- rf_rdDataB  input  DATA_W  read data B, combinational from rf_rdAddrB.
- rf_wrAddr  output  ADDR_W  write address.
- rf_wrData  output  DATA_W  write data.
- rf_write  output  1  write strobe, one cycle per command.
- done  output  1  one-cycle pulse when the command completes.
- res_data  output  DATA_W  result, held until the next done.
- res_zero  output  1  res_data == 0.
- res_carry  output  1  carry-out (ADD) / not-borrow (SUB); 0 for all other ops.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - rf_write, done, res_data, res_zero, res_carry, rf_wrAddr, rf_wrData, rf_rdAddrA, rf_rdAddrB = 0.
  - cmd_ready = 1 once reset is released.
  - Reset mid-command: the command is discarded, no write is issued, and rf_write drops to 0 immediately.
- FSM states and transitions:
  - IDLE: cmd_ready=1. If cmd_valid, latch op/dst/srcA/srcB/nowb, then go to RD.
  - RD: rf_rdAddrA/B = latched srcA/srcB. At the clock edge, capture rf_rdDataA/B into opA/opB, then go to EX.
  - EX: compute result, zero and carry into registers, then go to WR.
  - WR: rf_write = ~nowb, rf_wrAddr = dst, rf_wrData = result. done=1, with res_* valid in the same cycle. Then go to IDLE.
- Latency and throughput:
  - Command accepted at edge N; rf_write/done are asserted during cycle N+3.
  - Throughput is one command per 4 cycles.
  - cmd_ready=0 in RD/EX/WR. A command presented while busy stalls; the upstream side must hold it stable.
- rf_rdAddrA/B are 0 outside RD. rf_wrAddr/rf_wrData hold their last values; only rf_write qualifies them.
- Opcodes (all 32-bit, results truncated to DATA_W):
  - 0 ADD: A+B; carry = bit 32 of the 33-bit sum.
  - 1 SUB: A-B; carry = 1 when A >= B (unsigned).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: A << B[4:0].
  - 6 SRL: A >> B[4:0] (logical).
  - 7 PASSA: A (register copy).
- Boundary conditions:
  - srcA == srcB is legal; both ports read the same register.
  - dst == srcA/srcB is legal; the write occurs after the operands are captured, so old values are used.
  - Register 0 is an ordinary register (not hardwired).
  - cmd_valid held continuously: back-to-back commands are accepted in the IDLE cycle following each WR. The second command's RD therefore sees the first command's write.
  - nowb=1: done and res_* behave normally; rf_write stays 0.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - Opcode constants OP_ADD..OP_PASSA.
  - State encoding ST_IDLE=0, ST_RD=1, ST_EX=2, ST_WR=3.
- One sub-module: regfile_alu. Purely combinational; inputs op, a, b; outputs result, zero, carry. Instantiated once in EX.
- The FSM, operand registers and output registers live in regfile_op_sequencer.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-stream, including once while in EX -> all outputs 0, no rf_write, cmd_ready=1 after release.
- ADD with carry: r1=FFFF_FFFF, r2=0000_0002; ADD dst=3, A=1, B=2 -> rf_write at cycle N+3, rf_wrAddr=3, rf_wrData=0000_0001, res_carry=1, res_zero=0; r3 reads back 0000_0001.
- SUB to zero, in place: r5=ABCD_EFAB; SUB dst=5, A=5, B=5 -> res_data=0, res_zero=1, res_carry=1; r5 becomes 0.
- Shifts: r6=0123_4567, r7=0000_0004; SLL dst=8 -> 1234_5670. SRL dst=9 -> 0012_3456.
- nowb: r10=5555_5555; PASSA dst=11, A=10, nowb=1 -> done=1, res_data=5555_5555, rf_write never asserted; r11 unchanged.
- Back-to-back dependency: cmd_valid held for ADD r12=r1+r2 then AND r13=r12&r12 -> second cmd_ready at cycle N+4, r13 = r12 new value; busy low for exactly 1 cycle between commands.
